// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: upstream master for ram_uart.
// Arbitrates instruction fetch (IF) and data access (MEM) onto one bus
// request, runs the need_to_work / work_done handshake and returns results
// to the pipeline. A pipeline step with a load/store runs the MEM transaction
// first, then the fetch; the pipeline is released for one cycle when the fetch
// finishes.
// Optional build macro: MEM_TIMEOUT_EN -- bounds the wait on bus_done to
// TIMEOUT cycles, returns NOP/zero on expiry and sets the sticky err flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | pick owner (MEM if pending and not yet served, else IF)
// ISSUE     | request presented to ram_uart
// WAIT_LOW  | wait for bus_done to drop (request accepted)
// WAIT_HIGH | wait for bus_done to rise, capture bus_result
// DONE      | request dropped, update mem_served, IF owner releases stall

module mem_access_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_INST = 16'h0800,
    parameter int                TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              bus_need_to_work,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_done,
    input  logic [DATA_W-1:0] bus_result,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } state_t;

    state_t state;
    logic   owner_mem;
    logic   mem_served;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mem_access_ctrl: TIMEOUT must be at least 2");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == '0);
`else
    assign err = 1'b0;
`endif

    // Sequencer: owner selection, bus handshake, result capture and stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            owner_mem        <= 1'b0;
            mem_served       <= 1'b0;
            if_inst          <= NOP_INST;
            mem_rdata        <= '0;
            stall            <= 1'b1;
            bus_need_to_work <= 1'b0;
            bus_rd           <= 1'b0;
            bus_wr           <= 1'b0;
            bus_addr         <= '0;
            bus_wdata        <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt          <= '0;
            err              <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Strobes are set here so they are already valid while in ISSUE.
                    if ((mem_rd || mem_wr) && !mem_served) begin
                        owner_mem <= 1'b1;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_rd    <= !mem_wr;
                        bus_wr    <= mem_wr;
                    end else begin
                        owner_mem <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_rd    <= 1'b1;
                        bus_wr    <= 1'b0;
                    end
                    bus_need_to_work <= 1'b1;
                    state            <= S_ISSUE;
                end

                S_ISSUE: begin
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt <= CNT_W'(TIMEOUT - 1);
`endif
                    state <= S_WAIT_LOW;
                end

                S_WAIT_LOW: begin
                    if (!bus_done) begin
                        state <= S_WAIT_HIGH;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_hit) begin
                        if (!owner_mem) begin
                            if_inst <= NOP_INST;
                        end else if (bus_rd) begin
                            mem_rdata <= '0;
                        end
                        err              <= 1'b1;
                        bus_need_to_work <= 1'b0;
                        bus_rd           <= 1'b0;
                        bus_wr           <= 1'b0;
                        stall            <= owner_mem;
                        state            <= S_DONE;
                    end
                    tmo_cnt <= tmo_cnt - 1'b1;
`endif
                end

                S_WAIT_HIGH: begin
                    if (bus_done) begin
                        if (!owner_mem) begin
                            if_inst <= bus_result;
                        end else if (bus_rd) begin
                            mem_rdata <= bus_result;
                        end
                        bus_need_to_work <= 1'b0;
                        bus_rd           <= 1'b0;
                        bus_wr           <= 1'b0;
                        stall            <= owner_mem;
                        state            <= S_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_hit) begin
                        if (!owner_mem) begin
                            if_inst <= NOP_INST;
                        end else if (bus_rd) begin
                            mem_rdata <= '0;
                        end
                        err              <= 1'b1;
                        bus_need_to_work <= 1'b0;
                        bus_rd           <= 1'b0;
                        bus_wr           <= 1'b0;
                        stall            <= owner_mem;
                        state            <= S_DONE;
                    end
                    tmo_cnt <= tmo_cnt - 1'b1;
`endif
                end

                S_DONE: begin
                    // A served MEM access is not repeated until the following fetch completes.
                    mem_served <= owner_mem;
                    stall      <= 1'b1;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
